pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Decodes the 4-bit opcode in ID against the ID/EX and EX/MEM control bits and the EX-stage branch outcome.
- Drives the write-enable and flush signals of the PC and the stage registers, plus the PC source select.
- Handles load-use interlock, jump and branch flush, data-memory wait freeze with timeout, and illegal-opcode halt.

Parameters:
- RA_W, 4, register-index width.
- CNT_W, 16, width of the saturating performance counters.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before halting (must be ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_opcode  in  4  opcode of the instruction in ID.
- id_rs  in  RA_W  ID source register rs.
- id_rt  in  RA_W  ID source register rt.
- ex_mem_read  in  1  ID/EX MemRead (load in EX).
- ex_rt  in  RA_W  destination of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken (BEQ/BNE/BLT/BGT already qualified).
- mem_access  in  1  EX/MEM MemRead|MemWrite.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- pc_sel  out  2  00 sequential, 01 jump target, 10 branch target.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_write  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX bubble (control zeroed).
- exmem_write  out  1  EX/MEM enable.
- memwb_flush  out  1  MEM/WB bubble.
- halted  out  1  controller in HALT.
- illegal_op  out  1  sticky, illegal opcode seen.
- mem_timeout  out  1  sticky, memory wait timeout.
- stall_count  out  CNT_W  cycles with pc_write=0 outside HALT, saturating.
- flush_count  out  CNT_W  cycles with ifid_flush=1, saturating.

Behaviour:
- **State register:** states RUN, MEM_WAIT, HALT. Reset (rst_n=0 at clk edge) sets state=RUN, wait_cnt=0, all sticky flags 0, counters 0.
- **Outputs while rst_n=0:**
  - Enables: pc_write, ifid_write, idex_write, exmem_write = 0.
  - Flushes: ifid_flush, idex_flush, memwb_flush = 1.
  - pc_sel = 00.
- All other outputs are combinational from state and inputs (same-cycle). Counters and flags are registered.
- **Opcode classes** (package):
  - uses_rs: all opcodes except 1111.
  - uses_rt: 0000, 1000, 1001–1100.
  - jump: 1111.
  - illegal: 0101, 0110, 1101, 1110.
- **freeze** = mem_access & ~mem_ready.
  - pc_write, ifid_write, idex_write, exmem_write = 0; memwb_flush = 1.
  - All other actions are suppressed; branch/jump/illegal are re-evaluated once freeze clears.
  - Freeze has top priority in every state.
- **branch (no freeze)** = ex_branch_taken.
  - pc_sel=10, ifid_flush=1, idex_flush=1.
  - The ID instruction is wrong-path: jump, load-use and illegal checks are ignored.
- **jump (no freeze, no branch)**: opcode 1111 → pc_sel=01, ifid_flush=1.
- **load-use (no freeze, no branch)** = ex_mem_read & ex_rt≠0 & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
  - pc_write=0, ifid_write=0, idex_flush=1, for exactly one cycle per hazard.
  - Jump check is taken the following cycle.
- **illegal (no freeze, no branch, state RUN)**: pc_write=0, ifid_write=0, idex_flush=1; next state HALT; illegal_op←1.
- **Default**: all writes 1, flushes 0, pc_sel=00.
- **State transitions:**
  - RUN→MEM_WAIT on freeze; wait_cnt←1.
  - MEM_WAIT: on mem_ready → RUN, wait_cnt←0.
  - MEM_WAIT: else if wait_cnt==MEM_TIMEOUT-1 → HALT, mem_timeout←1.
  - MEM_WAIT: else wait_cnt++.
- **HALT:**
  - pc_write=0, ifid_write=0, idex_flush=1, halted=1.
  - EX/MEM and MEM/WB keep draining (freeze still applies).
  - Exits only by reset.
- **Counters:** each increments by 1 per qualifying cycle and holds at 2^CNT_W-1.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - opcode constants (OP_RTYPE=0000 … OP_JUMP=1111);
  - state enum;
  - PCSEL_SEQ/JMP/BR constants;
  - functions uses_rs, uses_rt, is_illegal.
- Sub-module sat_counter (CNT_W, inc) is instantiated twice.

Test Plan:
- **Reset release:** after reset, add (0000) in ID, no hazards → pc_write=1, all flushes 0, pc_sel=00, stall_count=0.
- **Load-use:** ex_mem_read=1, ex_rt=3, id_opcode=0000, id_rt=3 → one cycle of pc_write=0 + idex_flush=1, stall_count=1. Same with ex_rt=0 → no stall.
- **Branch vs jump:** ex_branch_taken=1 while id_opcode=1111 → pc_sel=10, ifid_flush=idex_flush=1, flush_count +1.
- **Memory wait:** mem_access=1, mem_ready=0 for 5 cycles then 1.
  - All enables 0 for 5 cycles; stall_count=5; state returns to RUN.
  - MEM_TIMEOUT=4 with mem_ready held 0 → HALT after 4 cycles, mem_timeout=1.
- **Illegal opcode:** id_opcode=0101 → illegal_op=1, halted=1 next cycle, pc_write stays 0. Same opcode with ex_branch_taken=1 → no halt.
- **Mid-operation reset:** rst_n=0 in HALT → next cycle state RUN, flags and counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode map, controller states, PC-source codes and opcode classifiers
// for the 5-stage pipeline hazard controller.
package pipeline_ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_ANDI  = 4'b0010;
   localparam logic [3:0] OP_ORI   = 4'b0011;
   localparam logic [3:0] OP_LW    = 4'b0100;
   localparam logic [3:0] OP_ILL5  = 4'b0101;
   localparam logic [3:0] OP_ILL6  = 4'b0110;
   localparam logic [3:0] OP_SLTI  = 4'b0111;
   localparam logic [3:0] OP_SW    = 4'b1000;
   localparam logic [3:0] OP_BEQ   = 4'b1001;
   localparam logic [3:0] OP_BNE   = 4'b1010;
   localparam logic [3:0] OP_BLT   = 4'b1011;
   localparam logic [3:0] OP_BGT   = 4'b1100;
   localparam logic [3:0] OP_ILL13 = 4'b1101;
   localparam logic [3:0] OP_ILL14 = 4'b1110;
   localparam logic [3:0] OP_JUMP  = 4'b1111;

   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_JMP = 2'b01;
   localparam logic [1:0] PCSEL_BR  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_HALT     = 2'b10
   } state_e;

   function automatic logic uses_rs(input logic [3:0] op);
      return (op != OP_JUMP);
   endfunction

   function automatic logic uses_rt(input logic [3:0] op);
      logic r;
      case (op)
         OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGT:            r = 1'b1;
         OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SLTI, OP_JUMP,
         OP_ILL5, OP_ILL6, OP_ILL13, OP_ILL14:                        r = 1'b0;
         default:                                                     r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op == OP_ILL5) || (op == OP_ILL6) || (op == OP_ILL13) || (op == OP_ILL14);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Counter that increments once per cycle with inc_i high and holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: load-use interlock, branch/jump flush,
// data-memory wait freeze with timeout, and illegal-opcode halt.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int RA_W        = 4,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       id_opcode,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             ex_mem_read,
   input  logic [RA_W-1:0]  ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_flush,
   output logic             halted,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            illegal_q, illegal_d;
   logic            timeout_q, timeout_d;
   logic            luse_q, luse_d;
   logic            freeze, active, luse_hazard, luse_stall, take_illegal;

   // active: the ID instruction is on the correct path and may act this cycle.
   always_comb begin
      freeze       = mem_access & ~mem_ready;
      active       = ~freeze & (state_q != ST_HALT) & ~ex_branch_taken;
      luse_hazard  = ex_mem_read & (ex_rt != '0) &
                     ((uses_rs(id_opcode) & (ex_rt == id_rs)) |
                      (uses_rt(id_opcode) & (ex_rt == id_rt)));
      luse_stall   = active & luse_hazard & ~luse_q;
      take_illegal = active & is_illegal(id_opcode);
   end

   always_comb begin
      pc_write    = 1'b1;
      pc_sel      = PCSEL_SEQ;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      memwb_flush = 1'b0;
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (freeze) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_flush = 1'b1;
      end else if (state_q == ST_HALT) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end else if (ex_branch_taken) begin
         pc_sel     = PCSEL_BR;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         if (id_opcode == OP_JUMP) begin
            pc_sel     = PCSEL_JMP;
            ifid_flush = 1'b1;
         end
         if (luse_stall || take_illegal) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   // luse_q blocks a second stall on the same hazard in the following cycle.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      luse_d     = luse_stall;
      if (take_illegal) begin
         state_d    = ST_HALT;
         illegal_d  = 1'b1;
         wait_cnt_d = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (freeze) begin
                  state_d    = ST_MEM_WAIT;
                  wait_cnt_d = WC_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  state_d    = ST_RUN;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                  state_d    = ST_HALT;
                  timeout_d  = 1'b1;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + WC_W'(1);
               end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         luse_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         luse_q     <= luse_d;
      end
   end

   assign halted      = (state_q == ST_HALT);
   assign illegal_op  = illegal_q;
   assign mem_timeout = timeout_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (~pc_write & (state_q != ST_HALT)),
      .count_o (stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (ifid_flush),
      .count_o (flush_count)
   );

endmodule
